// File: rtl/pix_ram_arbiter.sv
// pix_ram_arbiter
// Shares one read-only image RAM among NREQ pixel-scan engines. Each cycle a
// round-robin arbiter grants one (x,y) read request and turns it into a
// linear RAM address. The RAM data comes back one clock later and is routed
// to the granted requester together with a one-hot valid strobe.
// A request with coordinates outside the image is still granted, but it
// returns black (0) with roob set, and ram_q is ignored for it.
module pix_ram_arbiter #(
  parameter int NREQ  = 3,
  parameter int XW    = 6,
  parameter int YW    = 6,
  parameter int XRES  = 60,
  parameter int YRES  = 60,
  parameter int ADDRW = 12,
  parameter int COLW  = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ*YW-1:0]   req_y,
  input  logic                 stall,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [COLW-1:0]      rdata,
  output logic                 roob,
  output logic [ADDRW-1:0]     ram_addr,
  input  logic [COLW-1:0]      ram_q
);

  // Pointer width is wide enough to name every requester (NREQ is 2..4).
  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  rvalid_q, rvalid_d;
  logic             oob_q, oob_d;
  logic [NREQ-1:0]  gnt_s;
  logic             found_s;
  int               idx_s;
  logic [XW-1:0]    sel_x_s;
  logic [YW-1:0]    sel_y_s;
  logic [ADDRW-1:0] addr_s;

  // Round-robin search from ptr upward; selects the winner's coordinates.
  always_comb begin
    gnt_s   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    sel_x_s = '0;
    sel_y_s = '0;
    ptr_d   = ptr_q;
    if (resetn && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = int'(ptr_q) + k;
        if (idx_s >= NREQ) begin
          idx_s = idx_s - NREQ;
        end else begin
          idx_s = idx_s;
        end
        if (!found_s && req[idx_s]) begin
          found_s       = 1'b1;
          gnt_s[idx_s]  = 1'b1;
          sel_x_s       = req_x[idx_s*XW +: XW];
          sel_y_s       = req_y[idx_s*YW +: YW];
          if (idx_s == NREQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = PW'(idx_s + 1);
          end
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      gnt_s = '0;
    end
  end

  // Linear address of the granted pixel and its out-of-bounds flag.
  always_comb begin
    addr_s = '0;
    oob_d  = 1'b0;
    if (found_s) begin
      addr_s = ADDRW'(sel_y_s) * ADDRW'(XRES) + ADDRW'(sel_x_s);
      oob_d  = (int'(sel_x_s) >= XRES) || (int'(sel_y_s) >= YRES);
    end else begin
      addr_s = '0;
      oob_d  = 1'b0;
    end
  end

  // The response valid is simply the grant delayed by the RAM latency.
  always_comb begin
    rvalid_d = gnt_s;
  end

  // Pointer and pending-response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      oob_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      oob_q    <= oob_d;
    end
  end

  // Drive the outputs. A pending response is masked while resetn is low, so
  // a read accepted just before reset never shows up as a valid.
  always_comb begin
    gnt      = gnt_s;
    ram_addr = addr_s;
    rvalid   = rvalid_q & {NREQ{resetn}};
    roob     = oob_q & resetn;
    if (resetn && (|rvalid_q) && !oob_q) begin
      rdata = ram_q;
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: tb/tb_pix_ram_arbiter.sv
// Directed testbench for pix_ram_arbiter with a small RAM model whose
// contents are a fixed function of the address.
module tb_pix_ram_arbiter;

  logic        clk;
  logic        resetn;
  logic [2:0]  req;
  logic [17:0] req_x;
  logic [17:0] req_y;
  logic        stall;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  rdata;
  logic        roob;
  logic [11:0] ram_addr;
  logic [2:0]  ram_q;

  int checks;
  int errors;

  pix_ram_arbiter dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .req_x    (req_x),
    .req_y    (req_y),
    .stall    (stall),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .roob     (roob),
    .ram_addr (ram_addr),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, data = addr[2:0] ^ addr[5:3].
  always @(posedge clk) begin
    ram_q <= ram_addr[2:0] ^ ram_addr[5:3];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    req    = 3'b000;
    stall  = 1'b0;
    req_x  = 18'd0;
    req_y  = 18'd0;
    step;
    step;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req    = 3'b111;
    stall  = 1'b0;
    req_x  = 18'd0;
    req_y  = 18'd0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt0 got %b want 000", gnt); end
    step;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt1 got %b want 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b want 000", rvalid); end
    checks++; if (rdata !== 3'b000) begin errors++; $display("FAIL reset_rdata got %b want 000", rdata); end
    checks++; if (roob !== 1'b0) begin errors++; $display("FAIL reset_roob got %b want 0", roob); end
    step;
    resetn = 1'b1;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL reset_first_gnt got %b want 001", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_first_rvalid got %b want 000", rvalid); end
    req = 3'b000;
  endtask

  task automatic test_round_robin;
    logic [2:0] seq [6];
    logic [2:0] exp_rv;
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
    do_reset;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_rv = (k == 0) ? 3'b000 : seq[k-1];
      checks++; if (gnt !== seq[k]) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, seq[k]); end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL rr_rvalid[%0d] got %b want %b", k, rvalid, exp_rv); end
      step;
    end
    req = 3'b000;
    #1;
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL rr_rvalid_last got %b want 100", rvalid); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rr_idle_gnt got %b want 000", gnt); end
  endtask

  task automatic test_address;
    do_reset;
    req = 3'b010;
    req_x[6 +: 6] = 6'd5;
    req_y[6 +: 6] = 6'd2;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL addr_gnt got %b want 010", gnt); end
    checks++; if (ram_addr !== 12'd125) begin errors++; $display("FAIL addr_125 got %0d want 125", ram_addr); end
    step;
    req_x[6 +: 6] = 6'd59;
    req_y[6 +: 6] = 6'd59;
    #1;
    checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL addr_rvalid1 got %b want 010", rvalid); end
    checks++; if (rdata !== 3'b010) begin errors++; $display("FAIL addr_rdata125 got %b want 010", rdata); end
    checks++; if (roob !== 1'b0) begin errors++; $display("FAIL addr_roob1 got %b want 0", roob); end
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL addr_b2b_gnt got %b want 010", gnt); end
    checks++; if (ram_addr !== 12'd3599) begin errors++; $display("FAIL addr_3599 got %0d want 3599", ram_addr); end
    step;
    req = 3'b000;
    #1;
    checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL addr_rvalid2 got %b want 010", rvalid); end
    checks++; if (rdata !== 3'b110) begin errors++; $display("FAIL addr_rdata3599 got %b want 110", rdata); end
    checks++; if (ram_addr !== 12'd0) begin errors++; $display("FAIL addr_idle got %0d want 0", ram_addr); end
    step;
    #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL addr_rvalid_idle got %b want 000", rvalid); end
    checks++; if (rdata !== 3'b000) begin errors++; $display("FAIL addr_rdata_idle got %b want 000", rdata); end
  endtask

  task automatic test_out_of_bounds;
    do_reset;
    req = 3'b100;
    req_x[12 +: 6] = 6'd60;
    req_y[12 +: 6] = 6'd10;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL oob_gnt got %b want 100", gnt); end
    step;
    req = 3'b000;
    #1;
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL oob_rvalid got %b want 100", rvalid); end
    checks++; if (roob !== 1'b1) begin errors++; $display("FAIL oob_roob got %b want 1", roob); end
    checks++; if (rdata !== 3'b000) begin errors++; $display("FAIL oob_rdata got %b want 000", rdata); end
    step;
    #1;
    checks++; if (roob !== 1'b0) begin errors++; $display("FAIL oob_roob_clear got %b want 0", roob); end
  endtask

  task automatic test_stall;
    do_reset;
    req = 3'b011;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL stall_gnt0 got %b want 001", gnt); end
    step;
    stall = 1'b1;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL stall_gnt1 got %b want 000", gnt); end
    checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL stall_rvalid got %b want 001", rvalid); end
    step;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL stall_gnt2 got %b want 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL stall_rvalid2 got %b want 000", rvalid); end
    step;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL stall_gnt3 got %b want 000", gnt); end
    step;
    stall = 1'b0;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL stall_resume got %b want 010", gnt); end
    req = 3'b000;
  endtask

  task automatic test_reset_mid_op;
    do_reset;
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_gnt got %b want 001", gnt); end
    step;
    resetn = 1'b0;
    req    = 3'b000;
    #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_rvalid0 got %b want 000", rvalid); end
    step;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_rvalid1 got %b want 000", rvalid); end
    resetn = 1'b1;
    req    = 3'b111;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_ptr got %b want 001", gnt); end
    step;
    req = 3'b000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    req    = 3'b000;
    stall  = 1'b0;
    req_x  = 18'd0;
    req_y  = 18'd0;
    test_reset;
    test_round_robin;
    test_address;
    test_out_of_bounds;
    test_stall;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
